alu_cntrl_pipe: RTL
===================

ALU_CNTRL_PIPE -- requirements
Module: alu_cntrl_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of in_clk only.
REQ-002 Parameter FUNC_W, default 4, SHALL set the function-code width and SHALL be at least 4.
REQ-003 Parameter MUL_LAT, default 3, SHALL set the signed-multiply occupancy in cycles and SHALL be at least 1.
REQ-004 Parameter DIV_LAT, default 8, SHALL set the signed-divide occupancy in cycles and SHALL be at least 1.
REQ-005 Parameter CNT_W, default 8, SHALL set the width of the illegal-code counter.
REQ-006 in_clk  input  1  clock.
REQ-007 in_rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  upstream function code valid.
REQ-009 in_func  input  FUNC_W  function code.
REQ-010 in_ready  input  1  downstream accepts out_fc2/out_fc4 this cycle.
REQ-011 out_ready  output  1  block accepts in_func this cycle.
REQ-012 out_valid  output  1  registered decode valid.
REQ-013 out_fc2  output  2  operation class: 00 ALU, 01 memory, 10 branch, 11 illegal.
REQ-014 out_fc4  output  4  sub-operation code.
REQ-015 out_illegal  output  1  registered decode is an illegal code.
REQ-016 out_busy  output  1  multi-cycle occupancy counter nonzero.
REQ-017 out_illegal_cnt  output  CNT_W  saturating count of accepted illegal codes.

Function
REQ-018 Accept SHALL occur when in_valid=1 and out_ready=1; out_ready SHALL equal (out_valid=0 or in_ready=1) and busy count = 0.
REQ-019 On accept, the decode SHALL be registered with 1-cycle latency: out_valid=1 and the decoded fields visible in the following cycle.
REQ-020 The decode SHALL map in_func to (out_fc2, out_fc4) as follows: 0->00/0000, 1->00/0001, 2->00/0010, 3->00/0011, 4->00/0100, 5->00/0101, 6->00/1000, 7->00/1001, 8->00/1010, 9->00/1011, 10->01/0000, 11->01/0001, 12->10/0000, 13->10/0001, 14->10/0010.
REQ-021 Any in_func >= 15, including all upper codes when FUNC_W > 4, SHALL decode to out_fc2=11, out_fc4=0000, out_illegal=1; all legal codes SHALL give out_illegal=0.
REQ-022 When out_valid=1 and in_ready=1 with no new accept, out_valid SHALL clear in the next cycle.
REQ-023 When out_valid=1, in_ready=0: out_valid, out_fc2, out_fc4 and out_illegal SHALL hold unchanged.
REQ-024 Simultaneous consume and accept SHALL load the new decode and keep out_valid=1 with no bubble.
REQ-025 Accepting code 4 SHALL load the busy counter with MUL_LAT-1; accepting code 5 SHALL load it with DIV_LAT-1; other codes SHALL leave it unchanged (at 0).
REQ-026 A nonzero busy counter SHALL decrement by 1 every cycle, independent of in_ready; out_busy SHALL be 1 exactly while it is nonzero.
REQ-027 With MUL_LAT=1 or DIV_LAT=1, the counter SHALL stay 0 and back-to-back issue SHALL be allowed.
REQ-028 Each accepted illegal code SHALL increment out_illegal_cnt by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-029 in_func SHALL be ignored when out_ready=0; out_valid SHALL never assert without a preceding accept.

Reset
REQ-030 When in_rst=1 at an edge: out_valid=0, out_fc2=00, out_fc4=0000, out_illegal=0, busy counter=0, out_illegal_cnt=0; out_ready SHALL therefore be 1 in the first cycle after reset.
REQ-031 Reset SHALL override any simultaneous accept and SHALL abort a pending output or busy count mid-operation.

Verification
REQ-032 Codes 0..14, one per cycle, with in_ready=1 -> each table entry appears 1 cycle later; out_valid continuous; out_illegal=0.
REQ-033 in_func=15 accepted; FUNC_W=5, in_func=20 accepted -> out_fc2=11, out_fc4=0000, out_illegal=1; out_illegal_cnt increments 0->1->2.
REQ-034 Code 5 accepted with DIV_LAT=8 -> out_busy=1 for 7 cycles; out_ready=0 for those 7 cycles; next accept in cycle 8 after issue.
REQ-035 Decode held with in_ready=0 for 4 cycles while in_valid=1, in_func=2 -> outputs frozen, out_ready=0; in_ready=1 -> new 00/0010 loaded with no bubble.
REQ-036 CNT_W=2, 5 illegal accepts -> out_illegal_cnt reads 1,2,3,3,3.
REQ-037 in_rst pulsed 2 cycles into a divide busy period with out_valid=1 -> next cycle out_valid=0, out_busy=0, out_ready=1, out_illegal_cnt=0.

Source files
------------

// File: rtl/alu_cntrl_pipe.sv
// ALU control decode stage: function code -> (class, sub-op) with a one-entry output
// register, multi-cycle mul/div issue blocking and a saturating illegal-code counter.
module alu_cntrl_pipe #(
  parameter int unsigned FUNC_W  = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_valid,
  input  logic [FUNC_W-1:0] in_func,
  input  logic              in_ready,
  output logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        out_fc2,
  output logic [3:0]        out_fc4,
  output logic              out_illegal,
  output logic              out_busy,
  output logic [CNT_W-1:0]  out_illegal_cnt
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned BUSY_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [BUSY_W-1:0] MUL_LOAD = BUSY_W'(MUL_LAT - 1);
  localparam logic [BUSY_W-1:0] DIV_LOAD = BUSY_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic              r_valid;
  logic [1:0]        r_fc2;
  logic [3:0]        r_fc4;
  logic              r_illegal;
  logic [BUSY_W-1:0] r_busy_cnt;
  logic [CNT_W-1:0]  r_ill_cnt;

  logic       w_busy;
  logic       w_accept;
  logic       w_is_mul;
  logic       w_is_div;
  logic [3:0] w_code;
  logic [1:0] w_fc2;
  logic [3:0] w_fc4;
  logic       w_illegal;

  assign w_busy   = (r_busy_cnt != '0);
  assign w_accept = in_valid & out_ready;
  assign w_is_mul = (in_func == FUNC_W'(4));
  assign w_is_div = (in_func == FUNC_W'(5));
  assign w_code   = in_func[3:0];

  // Function-code decode; anything at or above 15 (any width) is illegal.
  always_comb begin
    w_fc2     = 2'b11;
    w_fc4     = 4'b0000;
    w_illegal = 1'b1;
    if (in_func < FUNC_W'(15)) begin
      w_illegal = 1'b0;
      case (w_code)
        4'd0:    begin w_fc2 = 2'b00; w_fc4 = 4'b0000; end
        4'd1:    begin w_fc2 = 2'b00; w_fc4 = 4'b0001; end
        4'd2:    begin w_fc2 = 2'b00; w_fc4 = 4'b0010; end
        4'd3:    begin w_fc2 = 2'b00; w_fc4 = 4'b0011; end
        4'd4:    begin w_fc2 = 2'b00; w_fc4 = 4'b0100; end
        4'd5:    begin w_fc2 = 2'b00; w_fc4 = 4'b0101; end
        4'd6:    begin w_fc2 = 2'b00; w_fc4 = 4'b1000; end
        4'd7:    begin w_fc2 = 2'b00; w_fc4 = 4'b1001; end
        4'd8:    begin w_fc2 = 2'b00; w_fc4 = 4'b1010; end
        4'd9:    begin w_fc2 = 2'b00; w_fc4 = 4'b1011; end
        4'd10:   begin w_fc2 = 2'b01; w_fc4 = 4'b0000; end
        4'd11:   begin w_fc2 = 2'b01; w_fc4 = 4'b0001; end
        4'd12:   begin w_fc2 = 2'b10; w_fc4 = 4'b0000; end
        4'd13:   begin w_fc2 = 2'b10; w_fc4 = 4'b0001; end
        4'd14:   begin w_fc2 = 2'b10; w_fc4 = 4'b0010; end
        default: begin w_fc2 = 2'b11; w_fc4 = 4'b0000; w_illegal = 1'b1; end
      endcase
    end
  end

  // Output register, busy countdown and illegal counter.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_valid    <= 1'b0;
      r_fc2      <= 2'b00;
      r_fc4      <= 4'b0000;
      r_illegal  <= 1'b0;
      r_busy_cnt <= '0;
      r_ill_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_fc2     <= w_fc2;
        r_fc4     <= w_fc4;
        r_illegal <= w_illegal;
      end else if (in_ready) begin
        r_valid <= 1'b0;
      end

      // Accept is only possible with the counter at zero, so load never races decrement.
      if (w_accept && w_is_mul) begin
        r_busy_cnt <= MUL_LOAD;
      end else if (w_accept && w_is_div) begin
        r_busy_cnt <= DIV_LOAD;
      end else if (w_busy) begin
        r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
      end

      if (w_accept && w_illegal && (r_ill_cnt != CNT_MAX)) begin
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
      end
    end
  end

  assign out_ready       = (~r_valid | in_ready) & ~w_busy;
  assign out_valid       = r_valid;
  assign out_fc2         = r_fc2;
  assign out_fc4         = r_fc4;
  assign out_illegal     = r_illegal;
  assign out_busy        = w_busy;
  assign out_illegal_cnt = r_ill_cnt;

endmodule
